// File: rtl/md_unit_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
// The decoder and the stall unit import this package as well as md_unit.
package md_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    function automatic int md_max(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: computes combinationally in the start cycle,
// then holds the result pending for a fixed latency before committing to HI/LO.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = $clog2(md_max(MULT_CYCLES, DIV_CYCLES) + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [31:0]      res_hi, res_lo, hi_q, lo_q;
    logic             res_dz;

    logic             is_arith, is_mult, op_signed;
    logic [63:0]      a_ext, b_ext, prod;
    logic             a_neg, b_neg, div_zero;
    logic [31:0]      a_mag, b_mag, b_safe, q_mag, r_mag;
    logic [31:0]      nxt_hi, nxt_lo;

    // NOTE: combinational blocks use blocking '=' with every output given a
    // default first, so no path leaves a value unassigned and no latch forms.
    always_comb begin
        is_arith  = (md_op <= MD_DIVU);
        is_mult   = (md_op == MD_MULT) || (md_op == MD_MULTU);
        op_signed = (md_op == MD_MULT) || (md_op == MD_DIV);

        a_ext = op_signed ? {{32{a[31]}}, a} : {32'd0, a};
        b_ext = op_signed ? {{32{b[31]}}, b} : {32'd0, b};
        prod  = a_ext * b_ext;

        // Sign-magnitude division: 0x80000000 / -1 falls out as 0x80000000 rem 0.
        a_neg    = op_signed & a[31];
        b_neg    = op_signed & b[31];
        a_mag    = a_neg ? (~a + 32'd1) : a;
        b_mag    = b_neg ? (~b + 32'd1) : b;
        div_zero = (b == 32'd0);
        b_safe   = div_zero ? 32'd1 : b_mag;
        q_mag    = a_mag / b_safe;
        r_mag    = a_mag % b_safe;

        nxt_hi = is_mult ? prod[63:32] : (a_neg ? (~r_mag + 32'd1) : r_mag);
        nxt_lo = is_mult ? prod[31:0]
                         : ((a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag);
    end

    // NOTE: sequential state uses non-blocking '<=' only; the pending result
    // registers are reset too, so a reset mid-operation can never leak a commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            res_hi <= '0;
            res_lo <= '0;
            res_dz <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE && !res_dz) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end else if (start) begin
            if (is_arith) begin
                cnt    <= is_mult ? MULT_LOAD : DIV_LOAD;
                res_hi <= nxt_hi;
                res_lo <= nxt_lo;
                res_dz <= !is_mult && div_zero;
            end else if (md_op == MD_MTHI) begin
                hi_q <= a;
            end else if (md_op == MD_MTLO) begin
                lo_q <= a;
            end
        end
    end

    assign busy = (start && is_arith) || (cnt != '0);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: latency shape, HI/LO results,
// move-to writes, ignored start while running, and asynchronous reset.
module tb_md_unit;
    import md_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] av, input logic [31:0] bv,
                          input int lat, input logic [31:0] eh, input logic [31:0] el);
        start = 1'b1; md_op = op; a = av; b = bv;
        #1;
        check({tag, " busy@start"}, {31'd0, busy}, 32'd1);
        tick();
        start = 1'b0;
        for (int i = 1; i <= lat; i++) begin
            check({tag, " busy@run"}, {31'd0, busy}, 32'd1);
            check({tag, " hi held"}, hi, model_hi);
            check({tag, " lo held"}, lo, model_lo);
            tick();
        end
        check({tag, " busy@done"}, {31'd0, busy}, 32'd0);
        check({tag, " hi"}, hi, eh);
        check({tag, " lo"}, lo, el);
        model_hi = eh;
        model_lo = el;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; md_op = 3'd0; a = 32'd0; b = 32'd0;
        tick();
        tick();
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        reset = 1'b1;
        tick();

        // mthi then mtlo on the next cycle; neither raises busy
        start = 1'b1; md_op = MD_MTHI; a = 32'hDEADBEEF;
        #1;
        check("mthi busy", {31'd0, busy}, 32'd0);
        tick();
        check("mthi hi", hi, 32'hDEADBEEF);
        md_op = MD_MTLO; a = 32'h1;
        #1;
        check("mtlo busy", {31'd0, busy}, 32'd0);
        tick();
        start = 1'b0;
        check("mtlo lo", lo, 32'h1);
        check("mtlo hi kept", hi, 32'hDEADBEEF);
        check("mt busy after", {31'd0, busy}, 32'd0);

        // reserved opcode does nothing
        start = 1'b1; md_op = 3'd6; a = 32'h5555_5555;
        #1;
        check("rsvd busy", {31'd0, busy}, 32'd0);
        tick();
        start = 1'b0;
        check("rsvd hi", hi, 32'hDEADBEEF);
        check("rsvd lo", lo, 32'h1);

        // reset asserted mid-run with cnt=3 abandons the mult
        start = 1'b1; md_op = MD_MULT; a = 32'hFFFFFFFE; b = 32'd3;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst hi", hi, 32'd0);
        check("midrst lo", lo, 32'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("postrst busy", {31'd0, busy}, 32'd0);
        check("postrst hi", hi, 32'd0);
        check("postrst lo", lo, 32'd0);
        model_hi = 32'd0;
        model_lo = 32'd0;

        run_op("mult",  MD_MULT,  32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("multu", MD_MULTU, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA);
        run_op("div",   MD_DIV,   32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu",  MD_DIVU,  32'd7, 32'd2, 10, 32'd1, 32'd3);
        run_op("divovf", MD_DIV,  32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);

        // divide by zero: full latency, HI/LO untouched
        start = 1'b1; md_op = MD_MTHI; a = 32'h1234;
        tick();
        md_op = MD_MTLO;
        tick();
        start = 1'b0;
        model_hi = 32'h1234;
        model_lo = 32'h1234;
        run_op("divu0", MD_DIVU, 32'd99, 32'd0, 10, 32'h1234, 32'h1234);

        // start+mthi during a running mult is ignored
        start = 1'b1; md_op = MD_MULT; a = 32'd5; b = 32'd6;
        tick();
        start = 1'b0;
        check("ign busy t+1", {31'd0, busy}, 32'd1);
        tick();
        start = 1'b1; md_op = MD_MTHI; a = 32'hAAAA_AAAA;
        #1;
        check("ign busy t+2", {31'd0, busy}, 32'd1);
        tick();
        start = 1'b0;
        check("ign hi t+3", hi, 32'h1234);
        tick();
        tick();
        check("ign busy t+5", {31'd0, busy}, 32'd1);
        tick();
        check("ign busy t+6", {31'd0, busy}, 32'd0);
        check("ign hi", hi, 32'd0);
        check("ign lo", lo, 32'd30);
        model_hi = 32'd0;
        model_lo = 32'd30;

        // back-to-back mult accepted in the first non-busy cycle
        run_op("b2b", MD_MULT, 32'h0001_0000, 32'h0001_0000, 5, 32'd1, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
